// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell fed LSB-first from operand
// shift registers, with the carry held in a flop between cycles.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_ps;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cf;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;

  logic               w_sum;
  logic               w_carry;
  logic [WIDTH-1:0]   w_ps_next;

  full_adder u_fa (
    .a     (r_sa[0]),
    .b     (r_sb[0]),
    .c     (r_cf),
    .sum   (w_sum),
    .carry (w_carry)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at index 0.
  assign w_ps_next = {w_sum, r_ps[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_ps    <= '0;
      r_cnt   <= '0;
      r_cf    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_cf    <= c;
            r_cnt   <= '0;
            r_ps    <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_cf  <= w_carry;
          r_ps  <= w_ps_next;
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_sum   <= w_ps_next;
            r_carry <= w_carry;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign carry = r_carry;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): latency, results, back-to-back
// issue, ignored start requests and asynchronous reset abort.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int checks = 0;
  int fails  = 0;

  logic [7:0] va [4] = '{8'h00, 8'h3C, 8'hFF, 8'hA5};
  logic [7:0] vb [4] = '{8'h00, 8'h42, 8'h01, 8'h5A};
  logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] vs [4] = '{8'h00, 8'h7E, 8'h00, 8'h00};
  logic       vk [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  // Stimulus only: call just after a negedge with the DUT idle. Returns at
  // the negedge where busy has dropped (or after a 30-cycle bound).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        output int lat, output int bcyc, output int dcnt, output int hold_err);
    logic [7:0] s0;
    logic       c0;
    s0 = sum; c0 = carry; lat = -1; bcyc = 0; dcnt = 0; hold_err = 0;
    a = ta; b = tb_v; c = tc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v; c = ~tc;
    for (int k = 0; k < 30; k++) begin
      if (busy) bcyc++;
      if (done) begin
        dcnt++;
        if (lat < 0) lat = k;
      end
      if (lat < 0 && (sum !== s0 || carry !== c0)) hold_err++;
      if (!busy && k > 0) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (sum !== 8'h00) begin fails++; $display("FAIL reset_sum got %h want 00", sum); end
    checks++; if (carry !== 1'b0) begin fails++; $display("FAIL reset_carry got %b want 0", carry); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
    $display("reset released: sum=%h carry=%b busy=%b done=%b", sum, carry, busy, done);
  endtask

  task automatic test_add();
    int lat, bcyc, dcnt, herr;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], lat, bcyc, dcnt, herr);
      $display("add a=%h b=%h c=%b -> sum=%h carry=%b lat=%0d busy=%0d", va[i], vb[i], vc[i], sum, carry, lat, bcyc);
      checks++; if (sum !== vs[i]) begin fails++; $display("FAIL add_sum[%0d] got %h want %h", i, sum, vs[i]); end
      checks++; if (carry !== vk[i]) begin fails++; $display("FAIL add_carry[%0d] got %b want %b", i, carry, vk[i]); end
      checks++; if (lat !== 8) begin fails++; $display("FAIL add_latency[%0d] got %0d want 8", i, lat); end
      checks++; if (bcyc !== 9) begin fails++; $display("FAIL add_busy[%0d] got %0d want 9", i, bcyc); end
      checks++; if (dcnt !== 1) begin fails++; $display("FAIL add_done_count[%0d] got %0d want 1", i, dcnt); end
      checks++; if (herr !== 0) begin fails++; $display("FAIL add_hold[%0d] got %0d want 0", i, herr); end
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, herr;
    logic [7:0] s1, s2;
    logic c1, c2, b9, b22;
    d1 = -1; d2 = -1; herr = 0; s1 = 'x; s2 = 'x; c1 = 'x; c2 = 'x; b9 = 'x; b22 = 'x;
    a = 8'hA5; b = 8'h5A; c = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h80; b = 8'h80; c = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (done) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k == 8)  begin s1 = sum; c1 = carry; end
      if (k == 9)  b9 = busy;
      if (k > 8 && k < 18 && (sum !== 8'h00 || carry !== 1'b1)) herr++;
      if (k == 10) start = 1'b0;
      if (k == 18) begin s2 = sum; c2 = carry; end
      if (k == 22) b22 = busy;
      @(negedge clk);
    end
    $display("b2b done at %0d and %0d: first=%h/%b second=%h/%b", d1, d2, s1, c1, s2, c2);
    checks++; if (d1 !== 8) begin fails++; $display("FAIL b2b_first_done got %0d want 8", d1); end
    checks++; if (d2 !== 18) begin fails++; $display("FAIL b2b_second_done got %0d want 18", d2); end
    checks++; if (s1 !== 8'h00 || c1 !== 1'b1) begin fails++; $display("FAIL b2b_first_result got %h/%b want 00/1", s1, c1); end
    checks++; if (b9 !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap got busy=%b want 0", b9); end
    checks++; if (herr !== 0) begin fails++; $display("FAIL b2b_hold got %0d want 0", herr); end
    checks++; if (s2 !== 8'h01 || c2 !== 1'b1) begin fails++; $display("FAIL b2b_second_result got %h/%b want 01/1", s2, c2); end
    checks++; if (b22 !== 1'b0) begin fails++; $display("FAIL b2b_no_third got busy=%b want 0", b22); end
  endtask

  task automatic test_ignore_start();
    int dcnt, dk, late;
    logic [7:0] s8;
    logic c8;
    dcnt = 0; dk = -1; late = 0; s8 = 'x; c8 = 'x;
    a = 8'h0F; b = 8'h01; c = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'hFF; c = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (done) begin
        dcnt++;
        if (dk < 0) dk = k;
      end
      if (k == 8) begin s8 = sum; c8 = carry; end
      if (k >= 9 && busy) late++;
      if (k == 3 || k == 8) start = 1'b1;
      if (k == 4 || k == 9) start = 1'b0;
      @(negedge clk);
    end
    $display("ignore: a=0F b=01 -> sum=%h carry=%b dones=%0d at %0d late_busy=%0d", s8, c8, dcnt, dk, late);
    checks++; if (dcnt !== 1) begin fails++; $display("FAIL ign_done_count got %0d want 1", dcnt); end
    checks++; if (dk !== 8) begin fails++; $display("FAIL ign_latency got %0d want 8", dk); end
    checks++; if (s8 !== 8'h10) begin fails++; $display("FAIL ign_sum got %h want 10", s8); end
    checks++; if (c8 !== 1'b0) begin fails++; $display("FAIL ign_carry got %b want 0", c8); end
    checks++; if (late !== 0) begin fails++; $display("FAIL ign_queued got %0d busy cycles want 0", late); end
  endtask

  task automatic test_reset_mid();
    int lat, bcyc, dcnt, herr;
    run_op(8'h3C, 8'h42, 1'b0, lat, bcyc, dcnt, herr);
    checks++; if (sum !== 8'h7E) begin fails++; $display("FAIL rm_prior_sum got %h want 7E", sum); end
    a = 8'hFF; b = 8'hFF; c = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    $display("mid-run reset: sum=%h carry=%b busy=%b done=%b", sum, carry, busy, done);
    checks++; if (sum !== 8'h00) begin fails++; $display("FAIL rm_sum got %h want 00", sum); end
    checks++; if (carry !== 1'b0) begin fails++; $display("FAIL rm_carry got %b want 0", carry); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL rm_done got %b want 0", done); end
    rst = 1'b0;
    run_op(8'h01, 8'h01, 1'b1, lat, bcyc, dcnt, herr);
    $display("restart a=01 b=01 c=1 -> sum=%h carry=%b lat=%0d", sum, carry, lat);
    checks++; if (sum !== 8'h03) begin fails++; $display("FAIL rm_restart_sum got %h want 03", sum); end
    checks++; if (carry !== 1'b0) begin fails++; $display("FAIL rm_restart_carry got %b want 0", carry); end
    checks++; if (lat !== 8) begin fails++; $display("FAIL rm_restart_latency got %0d want 8", lat); end
    checks++; if (dcnt !== 1) begin fails++; $display("FAIL rm_restart_done_count got %0d want 1", dcnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
